// File: rtl/altera_ace5lite_hps2fpga_responder_if.sv
// HPS-to-FPGA bus bundle: ACE5-Lite side from the HPS and plain AXI4 side toward the fabric.
// The responder uses the slave modport; whatever drives the HPS side and models the fabric uses master.
interface altera_ace5lite_hps2fpga_responder_if #(
  parameter int H2F_ADDRESS_WIDTH = 40,
  parameter int H2F_DATA_WIDTH    = 128,
  parameter int H2F_ID_WIDTH      = 4
);
  localparam int AW = H2F_ADDRESS_WIDTH;
  localparam int DW = H2F_DATA_WIDTH;
  localparam int IW = H2F_ID_WIDTH;
  localparam int SW = H2F_DATA_WIDTH / 8;

  logic [IW-1:0] ace5_hps2fpga_awid;
  logic [AW-1:0] ace5_hps2fpga_awaddr;
  logic [7:0]    ace5_hps2fpga_awlen;
  logic [2:0]    ace5_hps2fpga_awsize;
  logic [1:0]    ace5_hps2fpga_awburst;
  logic          ace5_hps2fpga_awlock;
  logic [3:0]    ace5_hps2fpga_awcache;
  logic [2:0]    ace5_hps2fpga_awprot;
  logic [3:0]    ace5_hps2fpga_awqos;
  logic [1:0]    ace5_hps2fpga_awdomain;
  logic [3:0]    ace5_hps2fpga_awsnoop;
  logic [1:0]    ace5_hps2fpga_awbar;
  logic [5:0]    ace5_hps2fpga_awatop;
  logic          ace5_hps2fpga_awstashniden;
  logic          ace5_hps2fpga_awvalid, ace5_hps2fpga_awready;
  logic [DW-1:0] ace5_hps2fpga_wdata;
  logic [SW-1:0] ace5_hps2fpga_wstrb;
  logic          ace5_hps2fpga_wlast, ace5_hps2fpga_wvalid, ace5_hps2fpga_wready;
  logic [IW-1:0] ace5_hps2fpga_bid;
  logic [1:0]    ace5_hps2fpga_bresp;
  logic          ace5_hps2fpga_bvalid, ace5_hps2fpga_bready;
  logic [IW-1:0] ace5_hps2fpga_arid;
  logic [AW-1:0] ace5_hps2fpga_araddr;
  logic [7:0]    ace5_hps2fpga_arlen;
  logic [2:0]    ace5_hps2fpga_arsize;
  logic [1:0]    ace5_hps2fpga_arburst;
  logic          ace5_hps2fpga_arlock;
  logic [3:0]    ace5_hps2fpga_arcache;
  logic [2:0]    ace5_hps2fpga_arprot;
  logic [3:0]    ace5_hps2fpga_arqos;
  logic [1:0]    ace5_hps2fpga_ardomain;
  logic [3:0]    ace5_hps2fpga_arsnoop;
  logic [1:0]    ace5_hps2fpga_arbar;
  logic          ace5_hps2fpga_arvalid, ace5_hps2fpga_arready;
  logic [IW-1:0] ace5_hps2fpga_rid;
  logic [DW-1:0] ace5_hps2fpga_rdata;
  logic [1:0]    ace5_hps2fpga_rresp;
  logic          ace5_hps2fpga_rlast, ace5_hps2fpga_rvalid, ace5_hps2fpga_rready;

  logic [IW-1:0] axi4_hps2fpga_awid;
  logic [AW-1:0] axi4_hps2fpga_awaddr;
  logic [7:0]    axi4_hps2fpga_awlen;
  logic [2:0]    axi4_hps2fpga_awsize;
  logic [1:0]    axi4_hps2fpga_awburst;
  logic          axi4_hps2fpga_awlock;
  logic [3:0]    axi4_hps2fpga_awcache;
  logic [2:0]    axi4_hps2fpga_awprot;
  logic [3:0]    axi4_hps2fpga_awqos;
  logic          axi4_hps2fpga_awvalid, axi4_hps2fpga_awready;
  logic [DW-1:0] axi4_hps2fpga_wdata;
  logic [SW-1:0] axi4_hps2fpga_wstrb;
  logic          axi4_hps2fpga_wlast, axi4_hps2fpga_wvalid, axi4_hps2fpga_wready;
  logic [IW-1:0] axi4_hps2fpga_bid;
  logic [1:0]    axi4_hps2fpga_bresp;
  logic          axi4_hps2fpga_bvalid, axi4_hps2fpga_bready;
  logic [IW-1:0] axi4_hps2fpga_arid;
  logic [AW-1:0] axi4_hps2fpga_araddr;
  logic [7:0]    axi4_hps2fpga_arlen;
  logic [2:0]    axi4_hps2fpga_arsize;
  logic [1:0]    axi4_hps2fpga_arburst;
  logic          axi4_hps2fpga_arlock;
  logic [3:0]    axi4_hps2fpga_arcache;
  logic [2:0]    axi4_hps2fpga_arprot;
  logic [3:0]    axi4_hps2fpga_arqos;
  logic          axi4_hps2fpga_arvalid, axi4_hps2fpga_arready;
  logic [IW-1:0] axi4_hps2fpga_rid;
  logic [DW-1:0] axi4_hps2fpga_rdata;
  logic [1:0]    axi4_hps2fpga_rresp;
  logic          axi4_hps2fpga_rlast, axi4_hps2fpga_rvalid, axi4_hps2fpga_rready;

  modport slave (
    input  ace5_hps2fpga_awid, ace5_hps2fpga_awaddr, ace5_hps2fpga_awlen, ace5_hps2fpga_awsize,
           ace5_hps2fpga_awburst, ace5_hps2fpga_awlock, ace5_hps2fpga_awcache, ace5_hps2fpga_awprot,
           ace5_hps2fpga_awqos, ace5_hps2fpga_awdomain, ace5_hps2fpga_awsnoop, ace5_hps2fpga_awbar,
           ace5_hps2fpga_awatop, ace5_hps2fpga_awstashniden, ace5_hps2fpga_awvalid,
    output ace5_hps2fpga_awready,
    input  ace5_hps2fpga_wdata, ace5_hps2fpga_wstrb, ace5_hps2fpga_wlast, ace5_hps2fpga_wvalid,
    output ace5_hps2fpga_wready,
    output ace5_hps2fpga_bid, ace5_hps2fpga_bresp, ace5_hps2fpga_bvalid,
    input  ace5_hps2fpga_bready,
    input  ace5_hps2fpga_arid, ace5_hps2fpga_araddr, ace5_hps2fpga_arlen, ace5_hps2fpga_arsize,
           ace5_hps2fpga_arburst, ace5_hps2fpga_arlock, ace5_hps2fpga_arcache, ace5_hps2fpga_arprot,
           ace5_hps2fpga_arqos, ace5_hps2fpga_ardomain, ace5_hps2fpga_arsnoop, ace5_hps2fpga_arbar,
           ace5_hps2fpga_arvalid,
    output ace5_hps2fpga_arready,
    output ace5_hps2fpga_rid, ace5_hps2fpga_rdata, ace5_hps2fpga_rresp, ace5_hps2fpga_rlast,
           ace5_hps2fpga_rvalid,
    input  ace5_hps2fpga_rready,
    output axi4_hps2fpga_awid, axi4_hps2fpga_awaddr, axi4_hps2fpga_awlen, axi4_hps2fpga_awsize,
           axi4_hps2fpga_awburst, axi4_hps2fpga_awlock, axi4_hps2fpga_awcache, axi4_hps2fpga_awprot,
           axi4_hps2fpga_awqos, axi4_hps2fpga_awvalid,
    input  axi4_hps2fpga_awready,
    output axi4_hps2fpga_wdata, axi4_hps2fpga_wstrb, axi4_hps2fpga_wlast, axi4_hps2fpga_wvalid,
    input  axi4_hps2fpga_wready,
    input  axi4_hps2fpga_bid, axi4_hps2fpga_bresp, axi4_hps2fpga_bvalid,
    output axi4_hps2fpga_bready,
    output axi4_hps2fpga_arid, axi4_hps2fpga_araddr, axi4_hps2fpga_arlen, axi4_hps2fpga_arsize,
           axi4_hps2fpga_arburst, axi4_hps2fpga_arlock, axi4_hps2fpga_arcache, axi4_hps2fpga_arprot,
           axi4_hps2fpga_arqos, axi4_hps2fpga_arvalid,
    input  axi4_hps2fpga_arready,
    input  axi4_hps2fpga_rid, axi4_hps2fpga_rdata, axi4_hps2fpga_rresp, axi4_hps2fpga_rlast,
           axi4_hps2fpga_rvalid,
    output axi4_hps2fpga_rready
  );

  modport master (
    output ace5_hps2fpga_awid, ace5_hps2fpga_awaddr, ace5_hps2fpga_awlen, ace5_hps2fpga_awsize,
           ace5_hps2fpga_awburst, ace5_hps2fpga_awlock, ace5_hps2fpga_awcache, ace5_hps2fpga_awprot,
           ace5_hps2fpga_awqos, ace5_hps2fpga_awdomain, ace5_hps2fpga_awsnoop, ace5_hps2fpga_awbar,
           ace5_hps2fpga_awatop, ace5_hps2fpga_awstashniden, ace5_hps2fpga_awvalid,
    input  ace5_hps2fpga_awready,
    output ace5_hps2fpga_wdata, ace5_hps2fpga_wstrb, ace5_hps2fpga_wlast, ace5_hps2fpga_wvalid,
    input  ace5_hps2fpga_wready,
    input  ace5_hps2fpga_bid, ace5_hps2fpga_bresp, ace5_hps2fpga_bvalid,
    output ace5_hps2fpga_bready,
    output ace5_hps2fpga_arid, ace5_hps2fpga_araddr, ace5_hps2fpga_arlen, ace5_hps2fpga_arsize,
           ace5_hps2fpga_arburst, ace5_hps2fpga_arlock, ace5_hps2fpga_arcache, ace5_hps2fpga_arprot,
           ace5_hps2fpga_arqos, ace5_hps2fpga_ardomain, ace5_hps2fpga_arsnoop, ace5_hps2fpga_arbar,
           ace5_hps2fpga_arvalid,
    input  ace5_hps2fpga_arready,
    input  ace5_hps2fpga_rid, ace5_hps2fpga_rdata, ace5_hps2fpga_rresp, ace5_hps2fpga_rlast,
           ace5_hps2fpga_rvalid,
    output ace5_hps2fpga_rready,
    input  axi4_hps2fpga_awid, axi4_hps2fpga_awaddr, axi4_hps2fpga_awlen, axi4_hps2fpga_awsize,
           axi4_hps2fpga_awburst, axi4_hps2fpga_awlock, axi4_hps2fpga_awcache, axi4_hps2fpga_awprot,
           axi4_hps2fpga_awqos, axi4_hps2fpga_awvalid,
    output axi4_hps2fpga_awready,
    input  axi4_hps2fpga_wdata, axi4_hps2fpga_wstrb, axi4_hps2fpga_wlast, axi4_hps2fpga_wvalid,
    output axi4_hps2fpga_wready,
    output axi4_hps2fpga_bid, axi4_hps2fpga_bresp, axi4_hps2fpga_bvalid,
    input  axi4_hps2fpga_bready,
    input  axi4_hps2fpga_arid, axi4_hps2fpga_araddr, axi4_hps2fpga_arlen, axi4_hps2fpga_arsize,
           axi4_hps2fpga_arburst, axi4_hps2fpga_arlock, axi4_hps2fpga_arcache, axi4_hps2fpga_arprot,
           axi4_hps2fpga_arqos, axi4_hps2fpga_arvalid,
    output axi4_hps2fpga_arready,
    output axi4_hps2fpga_rid, axi4_hps2fpga_rdata, axi4_hps2fpga_rresp, axi4_hps2fpga_rlast,
           axi4_hps2fpga_rvalid,
    input  axi4_hps2fpga_rready
  );
endinterface

// File: rtl/altera_ace5lite_hps2fpga_responder.sv
// ACE5-Lite to AXI4 bridge that forwards plain requests and optionally answers ACE-only requests
// locally with SLVERR. Optional rejection enabled by ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN.
module altera_ace5lite_hps2fpga_responder #(
  parameter int H2F_ADDRESS_WIDTH = 40,
  parameter int H2F_DATA_WIDTH    = 128,
  parameter int H2F_ID_WIDTH      = 4
) (
  input logic axi_clock,
  input logic axi_reset,
  altera_ace5lite_hps2fpga_responder_if.slave bus
);
  localparam int AW = H2F_ADDRESS_WIDTH;
  localparam int IW = H2F_ID_WIDTH;
  localparam int DW = H2F_DATA_WIDTH;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic [3:0]    cache;
    logic [2:0]    prot;
    logic [3:0]    qos;
  } ax_t;

`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_DRAIN, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_ERR} r_state_t;
`else
  typedef enum logic {W_IDLE, W_FWD} w_state_t;
  typedef enum logic {R_IDLE, R_FWD} r_state_t;
`endif

  w_state_t   w_state;
  r_state_t   r_state;
  ax_t        aw_in, ar_in, aw_q, ar_q;
  logic       rs;
  logic       aw_bad, ar_bad, w_drain, w_resp, r_err;
  logic       aw_pend, aw_done, w_done, ar_pend;
  logic [3:0] w_cnt, r_cnt;
  logic       aw_hs, ar_hs, wl_hs, aw_inc, b_dec, ar_inc, r_dec, b_err_hs, r_err_hs, r_err_last;
  logic       ace_unused;

  assign rs = axi_reset;

`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
  logic [7:0] beat;
  assign aw_bad  = (bus.ace5_hps2fpga_awatop != 6'd0) || (bus.ace5_hps2fpga_awsnoop != 4'd0) ||
                   (bus.ace5_hps2fpga_awbar != 2'd0) || bus.ace5_hps2fpga_awstashniden;
  assign ar_bad  = (bus.ace5_hps2fpga_arsnoop != 4'd0) || (bus.ace5_hps2fpga_arbar != 2'd0);
  assign w_drain = (w_state == W_DRAIN);
  assign w_resp  = (w_state == W_RESP);
  assign r_err   = (r_state == R_ERR);
  assign r_err_last = (beat == ar_q.len);
  assign ace_unused = ^{bus.ace5_hps2fpga_awdomain, bus.ace5_hps2fpga_ardomain};
`else
  assign aw_bad  = 1'b0;
  assign ar_bad  = 1'b0;
  assign w_drain = 1'b0;
  assign w_resp  = 1'b0;
  assign r_err   = 1'b0;
  assign r_err_last = 1'b0;
  assign ace_unused = ^{bus.ace5_hps2fpga_awdomain, bus.ace5_hps2fpga_awsnoop, bus.ace5_hps2fpga_awbar,
                        bus.ace5_hps2fpga_awatop, bus.ace5_hps2fpga_awstashniden,
                        bus.ace5_hps2fpga_ardomain, bus.ace5_hps2fpga_arsnoop, bus.ace5_hps2fpga_arbar};
`endif

  assign aw_in = '{id: bus.ace5_hps2fpga_awid, addr: bus.ace5_hps2fpga_awaddr, len: bus.ace5_hps2fpga_awlen,
                   size: bus.ace5_hps2fpga_awsize, burst: bus.ace5_hps2fpga_awburst,
                   lock: bus.ace5_hps2fpga_awlock, cache: bus.ace5_hps2fpga_awcache,
                   prot: bus.ace5_hps2fpga_awprot, qos: bus.ace5_hps2fpga_awqos};
  assign ar_in = '{id: bus.ace5_hps2fpga_arid, addr: bus.ace5_hps2fpga_araddr, len: bus.ace5_hps2fpga_arlen,
                   size: bus.ace5_hps2fpga_arsize, burst: bus.ace5_hps2fpga_arburst,
                   lock: bus.ace5_hps2fpga_arlock, cache: bus.ace5_hps2fpga_arcache,
                   prot: bus.ace5_hps2fpga_arprot, qos: bus.ace5_hps2fpga_arqos};

  // An error response may only start once nothing forwarded is in flight, so it cannot
  // overtake an earlier response with the same ID.
  assign bus.ace5_hps2fpga_awready = rs && (w_state == W_IDLE) && (w_cnt != 4'd15) && (!aw_bad || w_cnt == 4'd0);
  assign bus.ace5_hps2fpga_arready = rs && (r_state == R_IDLE) && (r_cnt != 4'd15) && (!ar_bad || r_cnt == 4'd0);

  assign {bus.axi4_hps2fpga_awid, bus.axi4_hps2fpga_awaddr, bus.axi4_hps2fpga_awlen, bus.axi4_hps2fpga_awsize,
          bus.axi4_hps2fpga_awburst, bus.axi4_hps2fpga_awlock, bus.axi4_hps2fpga_awcache,
          bus.axi4_hps2fpga_awprot, bus.axi4_hps2fpga_awqos} = aw_q;
  assign {bus.axi4_hps2fpga_arid, bus.axi4_hps2fpga_araddr, bus.axi4_hps2fpga_arlen, bus.axi4_hps2fpga_arsize,
          bus.axi4_hps2fpga_arburst, bus.axi4_hps2fpga_arlock, bus.axi4_hps2fpga_arcache,
          bus.axi4_hps2fpga_arprot, bus.axi4_hps2fpga_arqos} = ar_q;
  assign bus.axi4_hps2fpga_awvalid = rs && aw_pend;
  assign bus.axi4_hps2fpga_arvalid = rs && ar_pend;

  assign bus.axi4_hps2fpga_wdata  = bus.ace5_hps2fpga_wdata;
  assign bus.axi4_hps2fpga_wstrb  = bus.ace5_hps2fpga_wstrb;
  assign bus.axi4_hps2fpga_wlast  = bus.ace5_hps2fpga_wlast;
  assign bus.axi4_hps2fpga_wvalid = rs && (w_state == W_FWD) && bus.ace5_hps2fpga_wvalid;
  assign bus.ace5_hps2fpga_wready = rs && (((w_state == W_FWD) && bus.axi4_hps2fpga_wready) || w_drain);

  assign bus.ace5_hps2fpga_bvalid = rs && (w_resp || bus.axi4_hps2fpga_bvalid);
  assign bus.ace5_hps2fpga_bid    = w_resp ? aw_q.id : bus.axi4_hps2fpga_bid;
  assign bus.ace5_hps2fpga_bresp  = !rs ? 2'b00 : (w_resp ? 2'b10 : bus.axi4_hps2fpga_bresp);
  assign bus.axi4_hps2fpga_bready = rs && !w_resp && bus.ace5_hps2fpga_bready;

  assign bus.ace5_hps2fpga_rvalid = rs && (r_err || bus.axi4_hps2fpga_rvalid);
  assign bus.ace5_hps2fpga_rid    = r_err ? ar_q.id : bus.axi4_hps2fpga_rid;
  assign bus.ace5_hps2fpga_rdata  = r_err ? {DW{1'b0}} : bus.axi4_hps2fpga_rdata;
  assign bus.ace5_hps2fpga_rresp  = !rs ? 2'b00 : (r_err ? 2'b10 : bus.axi4_hps2fpga_rresp);
  assign bus.ace5_hps2fpga_rlast  = rs && (r_err ? r_err_last : bus.axi4_hps2fpga_rlast);
  assign bus.axi4_hps2fpga_rready = rs && !r_err && bus.ace5_hps2fpga_rready;

  assign aw_hs    = bus.ace5_hps2fpga_awvalid && bus.ace5_hps2fpga_awready;
  assign ar_hs    = bus.ace5_hps2fpga_arvalid && bus.ace5_hps2fpga_arready;
  assign wl_hs    = bus.ace5_hps2fpga_wvalid && bus.ace5_hps2fpga_wready && bus.ace5_hps2fpga_wlast;
  assign aw_inc   = bus.axi4_hps2fpga_awvalid && bus.axi4_hps2fpga_awready;
  assign b_dec    = bus.axi4_hps2fpga_bvalid && bus.axi4_hps2fpga_bready;
  assign ar_inc   = bus.axi4_hps2fpga_arvalid && bus.axi4_hps2fpga_arready;
  assign r_dec    = bus.axi4_hps2fpga_rvalid && bus.axi4_hps2fpga_rready && bus.axi4_hps2fpga_rlast;
  assign b_err_hs = w_resp && bus.ace5_hps2fpga_bready;
  assign r_err_hs = r_err && bus.ace5_hps2fpga_rready;

  always_ff @(posedge axi_clock) begin
    if (!axi_reset) begin
      w_state <= W_IDLE;
      aw_pend <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      w_cnt   <= '0;
      aw_q    <= '0;
    end else begin
      if (aw_inc && !b_dec && w_cnt != 4'd15) w_cnt <= w_cnt + 4'd1;
      else if (b_dec && !aw_inc && w_cnt != 4'd0) w_cnt <= w_cnt - 4'd1;
      if (aw_inc) aw_pend <= 1'b0;
      case (w_state)
        W_IDLE: if (aw_hs) begin
          aw_q    <= aw_in;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (aw_bad) begin
`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
            w_state <= W_DRAIN;
`endif
          end else begin
            w_state <= W_FWD;
            aw_pend <= 1'b1;
          end
        end
        // Downstream AW and the last W beat can complete in either order.
        W_FWD: begin
          if (aw_inc) aw_done <= 1'b1;
          if (wl_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_inc) && (w_done || wl_hs)) w_state <= W_IDLE;
        end
`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
        W_DRAIN: if (wl_hs) w_state <= W_RESP;
        W_RESP:  if (b_err_hs) w_state <= W_IDLE;
`endif
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_clock) begin
    if (!axi_reset) begin
      r_state <= R_IDLE;
      ar_pend <= 1'b0;
      r_cnt   <= '0;
      ar_q    <= '0;
`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
      beat    <= '0;
`endif
    end else begin
      if (ar_inc && !r_dec && r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
      else if (r_dec && !ar_inc && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      case (r_state)
        R_IDLE: if (ar_hs) begin
          ar_q <= ar_in;
          if (ar_bad) begin
`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
            r_state <= R_ERR;
            beat    <= '0;
`endif
          end else begin
            r_state <= R_FWD;
            ar_pend <= 1'b1;
          end
        end
        R_FWD: if (ar_inc) begin
          r_state <= R_IDLE;
          ar_pend <= 1'b0;
        end
`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
        R_ERR: if (r_err_hs) begin
          if (r_err_last) begin
            r_state <= R_IDLE;
            beat    <= '0;
          end else begin
            beat <= beat + 8'd1;
          end
        end
`endif
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_altera_ace5lite_hps2fpga_responder.sv
// Directed bench for the ACE5-Lite responder: reset gating, forwarding, counter stall, and
// (with ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN) local SLVERR handling.
module tb_altera_ace5lite_hps2fpga_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [127:0] exp_d;

  always #5 clk = ~clk;

  altera_ace5lite_hps2fpga_responder_if #(.H2F_ADDRESS_WIDTH(40), .H2F_DATA_WIDTH(128), .H2F_ID_WIDTH(4)) bus ();

  altera_ace5lite_hps2fpga_responder #(.H2F_ADDRESS_WIDTH(40), .H2F_DATA_WIDTH(128), .H2F_ID_WIDTH(4)) dut (
    .axi_clock(clk),
    .axi_reset(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ace5_hps2fpga_awid = '0; bus.ace5_hps2fpga_awaddr = '0; bus.ace5_hps2fpga_awlen = '0;
    bus.ace5_hps2fpga_awsize = 3'd4; bus.ace5_hps2fpga_awburst = 2'd1; bus.ace5_hps2fpga_awlock = 1'b0;
    bus.ace5_hps2fpga_awcache = '0; bus.ace5_hps2fpga_awprot = '0; bus.ace5_hps2fpga_awqos = '0;
    bus.ace5_hps2fpga_awdomain = '0; bus.ace5_hps2fpga_awsnoop = '0; bus.ace5_hps2fpga_awbar = '0;
    bus.ace5_hps2fpga_awatop = '0; bus.ace5_hps2fpga_awstashniden = 1'b0; bus.ace5_hps2fpga_awvalid = 1'b0;
    bus.ace5_hps2fpga_wdata = '0; bus.ace5_hps2fpga_wstrb = '1; bus.ace5_hps2fpga_wlast = 1'b0;
    bus.ace5_hps2fpga_wvalid = 1'b0; bus.ace5_hps2fpga_bready = 1'b0;
    bus.ace5_hps2fpga_arid = '0; bus.ace5_hps2fpga_araddr = '0; bus.ace5_hps2fpga_arlen = '0;
    bus.ace5_hps2fpga_arsize = 3'd4; bus.ace5_hps2fpga_arburst = 2'd1; bus.ace5_hps2fpga_arlock = 1'b0;
    bus.ace5_hps2fpga_arcache = '0; bus.ace5_hps2fpga_arprot = '0; bus.ace5_hps2fpga_arqos = '0;
    bus.ace5_hps2fpga_ardomain = '0; bus.ace5_hps2fpga_arsnoop = '0; bus.ace5_hps2fpga_arbar = '0;
    bus.ace5_hps2fpga_arvalid = 1'b0; bus.ace5_hps2fpga_rready = 1'b0;
    bus.axi4_hps2fpga_awready = 1'b0; bus.axi4_hps2fpga_wready = 1'b0;
    bus.axi4_hps2fpga_bid = '0; bus.axi4_hps2fpga_bresp = '0; bus.axi4_hps2fpga_bvalid = 1'b0;
    bus.axi4_hps2fpga_arready = 1'b0;
    bus.axi4_hps2fpga_rid = '0; bus.axi4_hps2fpga_rdata = '0; bus.axi4_hps2fpga_rresp = '0;
    bus.axi4_hps2fpga_rlast = 1'b0; bus.axi4_hps2fpga_rvalid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Reset with everything upstream and downstream shouting: all valid/ready outputs must stay low.
    bus.ace5_hps2fpga_awvalid = 1'b1; bus.ace5_hps2fpga_arvalid = 1'b1; bus.ace5_hps2fpga_wvalid = 1'b1;
    bus.ace5_hps2fpga_bready = 1'b1; bus.ace5_hps2fpga_rready = 1'b1;
    bus.axi4_hps2fpga_awready = 1'b1; bus.axi4_hps2fpga_wready = 1'b1; bus.axi4_hps2fpga_arready = 1'b1;
    bus.axi4_hps2fpga_bvalid = 1'b1; bus.axi4_hps2fpga_bresp = 2'b11;
    bus.axi4_hps2fpga_rvalid = 1'b1; bus.axi4_hps2fpga_rlast = 1'b1; bus.axi4_hps2fpga_rresp = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", bus.ace5_hps2fpga_awready, 0);
    chk("rst_arready", bus.ace5_hps2fpga_arready, 0);
    chk("rst_wready", bus.ace5_hps2fpga_wready, 0);
    chk("rst_bvalid", bus.ace5_hps2fpga_bvalid, 0);
    chk("rst_bresp", bus.ace5_hps2fpga_bresp, 0);
    chk("rst_rvalid", bus.ace5_hps2fpga_rvalid, 0);
    chk("rst_rresp", bus.ace5_hps2fpga_rresp, 0);
    chk("rst_rlast", bus.ace5_hps2fpga_rlast, 0);
    chk("rst_axi_awvalid", bus.axi4_hps2fpga_awvalid, 0);
    chk("rst_axi_arvalid", bus.axi4_hps2fpga_arvalid, 0);
    chk("rst_axi_wvalid", bus.axi4_hps2fpga_wvalid, 0);
    chk("rst_axi_bready", bus.axi4_hps2fpga_bready, 0);
    chk("rst_axi_rready", bus.axi4_hps2fpga_rready, 0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_awready", bus.ace5_hps2fpga_awready, 1);
    chk("post_rst_arready", bus.ace5_hps2fpga_arready, 1);
    chk("post_rst_axi_awvalid", bus.axi4_hps2fpga_awvalid, 0);

    // Forwarded 8-beat read, id 2.
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b1; bus.ace5_hps2fpga_arid = 4'd2; bus.ace5_hps2fpga_arlen = 8'd7;
    bus.ace5_hps2fpga_araddr = 40'h00_0000_1000;
    #1 chk("ar_ready", bus.ace5_hps2fpga_arready, 1);
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b0;
    #1;
    chk("ar_fwd_valid", bus.axi4_hps2fpga_arvalid, 1);
    chk("ar_fwd_id", bus.axi4_hps2fpga_arid, 2);
    chk("ar_fwd_len", bus.axi4_hps2fpga_arlen, 7);
    chk("ar_fwd_addr", bus.axi4_hps2fpga_araddr, 40'h00_0000_1000);
    @(negedge clk);
    bus.axi4_hps2fpga_arready = 1'b1;
    #1 chk("ar_fwd_hold", bus.axi4_hps2fpga_arvalid, 1);
    @(negedge clk);
    bus.axi4_hps2fpga_arready = 1'b0;
    #1 chk("ar_fwd_drop", bus.axi4_hps2fpga_arvalid, 0);
    bus.ace5_hps2fpga_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = {4{32'hA500_0000 + 32'(i)}};
      bus.axi4_hps2fpga_rvalid = 1'b1; bus.axi4_hps2fpga_rid = 4'd2; bus.axi4_hps2fpga_rdata = exp_d;
      bus.axi4_hps2fpga_rlast = (i == 7); bus.axi4_hps2fpga_rresp = 2'b00;
      #1;
      chk("r_pass_data", bus.ace5_hps2fpga_rdata, exp_d);
      chk("r_pass_last", bus.ace5_hps2fpga_rlast, (i == 7));
    end
    @(negedge clk);
    bus.axi4_hps2fpga_rvalid = 1'b0; bus.axi4_hps2fpga_rlast = 1'b0; bus.ace5_hps2fpga_rready = 1'b0;
    #1 chk("r_cnt_zero", dut.r_cnt, 0);

    // Forwarded 2-beat write, id 1; in the plain build a snoop field is simply ignored.
    @(negedge clk);
    bus.ace5_hps2fpga_awvalid = 1'b1; bus.ace5_hps2fpga_awid = 4'd1; bus.ace5_hps2fpga_awlen = 8'd1;
    bus.ace5_hps2fpga_awaddr = 40'h00_0000_2000;
`ifndef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
    bus.ace5_hps2fpga_awsnoop = 4'h1;
`endif
    #1 chk("aw_ready", bus.ace5_hps2fpga_awready, 1);
    @(negedge clk);
    bus.ace5_hps2fpga_awvalid = 1'b0; bus.ace5_hps2fpga_awsnoop = 4'h0;
    bus.axi4_hps2fpga_awready = 1'b1; bus.axi4_hps2fpga_wready = 1'b1;
    bus.ace5_hps2fpga_wvalid = 1'b1; bus.ace5_hps2fpga_wdata = 128'h1111; bus.ace5_hps2fpga_wlast = 1'b0;
    #1;
    chk("aw_fwd_valid", bus.axi4_hps2fpga_awvalid, 1);
    chk("aw_fwd_addr", bus.axi4_hps2fpga_awaddr, 40'h00_0000_2000);
    chk("aw_fwd_len", bus.axi4_hps2fpga_awlen, 1);
    chk("w_fwd_valid0", bus.axi4_hps2fpga_wvalid, 1);
    chk("w_fwd_data0", bus.axi4_hps2fpga_wdata, 128'h1111);
    @(negedge clk);
    bus.axi4_hps2fpga_awready = 1'b0;
    bus.ace5_hps2fpga_wdata = 128'h2222; bus.ace5_hps2fpga_wlast = 1'b1;
    #1;
    chk("aw_fwd_done", bus.axi4_hps2fpga_awvalid, 0);
    chk("w_fwd_data1", bus.axi4_hps2fpga_wdata, 128'h2222);
    chk("w_fwd_ready1", bus.ace5_hps2fpga_wready, 1);
    @(negedge clk);
    bus.ace5_hps2fpga_wvalid = 1'b0; bus.ace5_hps2fpga_wlast = 1'b0;
    bus.axi4_hps2fpga_bvalid = 1'b1; bus.axi4_hps2fpga_bid = 4'd1; bus.axi4_hps2fpga_bresp = 2'b00;
    bus.ace5_hps2fpga_bready = 1'b1;
    #1;
    chk("w_fwd_idle_wready", bus.ace5_hps2fpga_wready, 0);
    chk("b_pass_valid", bus.ace5_hps2fpga_bvalid, 1);
    chk("b_pass_id", bus.ace5_hps2fpga_bid, 1);
    chk("b_pass_resp", bus.ace5_hps2fpga_bresp, 0);
    @(negedge clk);
    bus.axi4_hps2fpga_bvalid = 1'b0; bus.ace5_hps2fpga_bready = 1'b0;
    #1 chk("w_cnt_zero", dut.w_cnt, 0);

    // Sixteen single-beat writes with no B coming back: the 16th stalls until one B returns.
    bus.axi4_hps2fpga_awready = 1'b1; bus.axi4_hps2fpga_wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.ace5_hps2fpga_wvalid = 1'b0; bus.ace5_hps2fpga_wlast = 1'b0;
      bus.ace5_hps2fpga_awvalid = 1'b1; bus.ace5_hps2fpga_awid = 4'(i); bus.ace5_hps2fpga_awlen = 8'd0;
      #1 chk("aw_sat_ready", bus.ace5_hps2fpga_awready, (i < 15));
      if (i == 15) begin
        bus.axi4_hps2fpga_bvalid = 1'b1; bus.axi4_hps2fpga_bid = 4'd0; bus.ace5_hps2fpga_bready = 1'b1;
        @(negedge clk);
        bus.axi4_hps2fpga_bvalid = 1'b0; bus.ace5_hps2fpga_bready = 1'b0;
        #1 chk("aw_sat_reopen", bus.ace5_hps2fpga_awready, 1);
      end
      @(negedge clk);
      bus.ace5_hps2fpga_awvalid = 1'b0;
      bus.ace5_hps2fpga_wvalid = 1'b1; bus.ace5_hps2fpga_wlast = 1'b1; bus.ace5_hps2fpga_wdata = 128'(i);
    end
    @(negedge clk);
    bus.ace5_hps2fpga_wvalid = 1'b0; bus.ace5_hps2fpga_wlast = 1'b0;
    #1 chk("w_cnt_full", dut.w_cnt, 15);
    bus.axi4_hps2fpga_bvalid = 1'b1; bus.ace5_hps2fpga_bready = 1'b1;
    repeat (15) @(negedge clk);
    bus.axi4_hps2fpga_bvalid = 1'b0; bus.ace5_hps2fpga_bready = 1'b0;
    bus.axi4_hps2fpga_awready = 1'b0; bus.axi4_hps2fpga_wready = 1'b0;
    #1 chk("w_cnt_drained", dut.w_cnt, 0);

`ifdef ALTERA_ACE5LITE_REJECT_UNSUPPORTED_EN
    // Atomic write is drained locally and answered with SLVERR.
    @(negedge clk);
    bus.ace5_hps2fpga_awvalid = 1'b1; bus.ace5_hps2fpga_awid = 4'd5; bus.ace5_hps2fpga_awlen = 8'd3;
    bus.ace5_hps2fpga_awatop = 6'h20;
    #1 chk("err_aw_ready", bus.ace5_hps2fpga_awready, 1);
    @(negedge clk);
    bus.ace5_hps2fpga_awvalid = 1'b0; bus.ace5_hps2fpga_awatop = 6'h00;
    for (int i = 0; i < 4; i++) begin
      bus.ace5_hps2fpga_wvalid = 1'b1; bus.ace5_hps2fpga_wlast = (i == 3); bus.ace5_hps2fpga_wdata = 128'(i);
      #1;
      chk("err_w_ready", bus.ace5_hps2fpga_wready, 1);
      chk("err_axi_wvalid", bus.axi4_hps2fpga_wvalid, 0);
      chk("err_axi_awvalid", bus.axi4_hps2fpga_awvalid, 0);
      chk("err_b_early", bus.ace5_hps2fpga_bvalid, 0);
      @(negedge clk);
    end
    bus.ace5_hps2fpga_wvalid = 1'b0; bus.ace5_hps2fpga_wlast = 1'b0; bus.ace5_hps2fpga_bready = 1'b1;
    #1;
    chk("err_b_valid", bus.ace5_hps2fpga_bvalid, 1);
    chk("err_b_id", bus.ace5_hps2fpga_bid, 5);
    chk("err_b_resp", bus.ace5_hps2fpga_bresp, 2'b10);
    chk("err_axi_bready", bus.axi4_hps2fpga_bready, 0);
    @(negedge clk);
    bus.ace5_hps2fpga_bready = 1'b0;
    #1 chk("err_b_done", bus.ace5_hps2fpga_bvalid, 0);

    // Barrier read waits behind one forwarded read, then returns three SLVERR beats.
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b1; bus.ace5_hps2fpga_arid = 4'd1; bus.ace5_hps2fpga_arlen = 8'd0;
    bus.axi4_hps2fpga_arready = 1'b1;
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b0;
    @(negedge clk);
    bus.axi4_hps2fpga_arready = 1'b0;
    bus.ace5_hps2fpga_arvalid = 1'b1; bus.ace5_hps2fpga_arid = 4'd3; bus.ace5_hps2fpga_arlen = 8'd2;
    bus.ace5_hps2fpga_arbar = 2'b01;
    #1 chk("err_ar_blocked0", bus.ace5_hps2fpga_arready, 0);
    @(negedge clk);
    #1 chk("err_ar_blocked1", bus.ace5_hps2fpga_arready, 0);
    bus.axi4_hps2fpga_rvalid = 1'b1; bus.axi4_hps2fpga_rid = 4'd1; bus.axi4_hps2fpga_rlast = 1'b1;
    bus.axi4_hps2fpga_rdata = 128'h77; bus.ace5_hps2fpga_rready = 1'b1;
    #1 chk("err_ar_blocked2", bus.ace5_hps2fpga_arready, 0);
    @(negedge clk);
    bus.axi4_hps2fpga_rvalid = 1'b0; bus.axi4_hps2fpga_rlast = 1'b0;
    #1 chk("err_ar_open", bus.ace5_hps2fpga_arready, 1);
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b0; bus.ace5_hps2fpga_arbar = 2'b00; bus.ace5_hps2fpga_rready = 1'b0;
    #1;
    chk("err_r_stall_valid", bus.ace5_hps2fpga_rvalid, 1);
    chk("err_r_axi_rready", bus.axi4_hps2fpga_rready, 0);
    @(negedge clk);
    bus.ace5_hps2fpga_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_r_valid", bus.ace5_hps2fpga_rvalid, 1);
      chk("err_r_id", bus.ace5_hps2fpga_rid, 3);
      chk("err_r_resp", bus.ace5_hps2fpga_rresp, 2'b10);
      chk("err_r_data", bus.ace5_hps2fpga_rdata, 0);
      chk("err_r_last", bus.ace5_hps2fpga_rlast, (i == 2));
      @(negedge clk);
    end
    #1 chk("err_r_done", bus.ace5_hps2fpga_rvalid, 0);

    // Reset in the middle of a 4-beat error burst abandons it.
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b1; bus.ace5_hps2fpga_arid = 4'd4; bus.ace5_hps2fpga_arlen = 8'd3;
    bus.ace5_hps2fpga_arbar = 2'b01;
    @(negedge clk);
    bus.ace5_hps2fpga_arvalid = 1'b0; bus.ace5_hps2fpga_arbar = 2'b00;
    #1 chk("rst_mid_beat0", bus.ace5_hps2fpga_rlast, 0);
    repeat (2) @(negedge clk);
    #1 chk("rst_mid_beat2", bus.ace5_hps2fpga_rvalid, 1);
    rst_n = 1'b0;
    #1 chk("rst_mid_gated", bus.ace5_hps2fpga_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_mid_no_beats", bus.ace5_hps2fpga_rvalid, 0);
      @(negedge clk);
    end
    bus.ace5_hps2fpga_rready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
